// File: rtl/tiny_synth_pkg.sv
// Shared constants and word types for the tiny synth voice datapath.
// The waveform generators use the same phase width as the accumulator.
package tiny_synth_pkg;
  localparam int ACC_BITS_DEFAULT  = 24;
  localparam int FREQ_BITS_DEFAULT = 16;

  typedef logic [ACC_BITS_DEFAULT-1:0]  phase_t;
  typedef logic [FREQ_BITS_DEFAULT-1:0] freq_t;
endpackage

// File: rtl/rise_edge_detect.sv
// One-clk pulse on a rising edge of din, compared against its registered previous value.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
  end

  assign pulse = din & ~din_q;
endmodule

// File: rtl/phase_accumulator.sv
// Per-voice phase accumulator: advances by a double-buffered frequency word on each sample_tick.
// Define PHASE_ACC_SYNC_EN to add the sync_in port and hard-sync to a master voice's wrap.
module phase_accumulator
  import tiny_synth_pkg::*;
#(
  parameter int ACCUMULATOR_BITS = ACC_BITS_DEFAULT,
  parameter int FREQ_BITS        = FREQ_BITS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_tick,
  input  logic [FREQ_BITS-1:0]        freq_in,
  input  logic                        freq_load,
  input  logic                        phase_reset,
`ifdef PHASE_ACC_SYNC_EN
  input  logic                        sync_in,
`endif
  output logic [ACCUMULATOR_BITS-1:0] accumulator,
  output logic                        wrap
);
  localparam int SUM_BITS = ACCUMULATOR_BITS + 1;

  logic [ACCUMULATOR_BITS-1:0] acc_q, acc_d;
  logic                        wrap_q, wrap_d;
  logic [FREQ_BITS-1:0]        pend_freq_q, pend_freq_d;
  logic [FREQ_BITS-1:0]        act_freq_q, act_freq_d;
  logic [SUM_BITS-1:0]         sum;
  logic                        sync_fire;

  // Extra top bit of the sum is the carry that becomes the wrap pulse.
  assign sum = SUM_BITS'(acc_q) + SUM_BITS'(act_freq_q);

`ifdef PHASE_ACC_SYNC_EN
  logic sync_rise;
  logic sync_pend_q, sync_pend_d;

  rise_edge_detect u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sync_in),
    .pulse (sync_rise)
  );

  // An edge landing on the tick clk is honoured at that tick, not deferred.
  assign sync_fire = sample_tick & (sync_pend_q | sync_rise);

  always_comb begin
    sync_pend_d = sync_pend_q | sync_rise;
    if (phase_reset || sample_tick) sync_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pend_q <= 1'b0;
    else        sync_pend_q <= sync_pend_d;
  end
`else
  assign sync_fire = 1'b0;
`endif

  always_comb begin
    pend_freq_d = freq_load ? freq_in : pend_freq_q;
    act_freq_d  = act_freq_q;
    if (sample_tick) act_freq_d = freq_load ? freq_in : pend_freq_q;

    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (phase_reset)      acc_d = '0;
    else if (sync_fire)   acc_d = '0;
    else if (sample_tick) {wrap_d, acc_d} = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      wrap_q      <= 1'b0;
      pend_freq_q <= '0;
      act_freq_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      wrap_q      <= wrap_d;
      pend_freq_q <= pend_freq_d;
      act_freq_q  <= act_freq_d;
    end
  end

  assign accumulator = acc_q;
  assign wrap        = wrap_q;
endmodule
